pipe_mult: RTL and testbench
============================

Name: pipe_mult

Overview:
- Parametrised pipelined integer multiplier. Successor to the fixed 4x4 pipelined multiplier.
- Generalised in operand width and pipeline depth.
- Adds per-transaction signed/unsigned mode, a valid/ready handshake with backpressure, and a sideband tag carried alongside each product.
- Sits between operand sources and downstream consumers in the datapath; one product per cycle at full throughput.

Parameters:
- WIDTH, 4, operand width in bits; WIDTH >= 2.
- STAGES, 4, pipeline register stages; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0 (elaboration error otherwise).
- TAG_W, 4, width of sideband tag passed through unchanged.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/tag/mode valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- data_a  input  WIDTH  multiplicand.
- data_b  input  WIDTH  multiplier.
- mode_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result/out_tag valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  2*WIDTH  exact product.
- out_tag  output  TAG_W  tag of the transaction on result.

Behaviour:
- Reset (async, immediate on rst=1):
  - all stage valid bits, out_valid, result and out_tag cleared to 0; in-flight transactions discarded.
  - in_ready = 1 while in reset and after release.
- Advance enable: adv = !out_valid || out_ready (combinational). in_ready = adv.
- Pipeline motion:
  - all stages move together when adv=1 and hold completely when adv=0 (global stall, no bubble squeezing).
  - Stage 1 captures {in_valid, a, b, mode, tag} on every adv edge; in_valid=0 inserts a bubble.
- Transfers:
  - input transfer = in_valid && in_ready at a rising edge;
  - output transfer = out_valid && out_ready at a rising edge.
- Latency:
  - transaction accepted at edge t is presented on result/out_valid right after edge t+STAGES-1, provided adv=1 on every edge in between.
  - STAGES=1: result registered at the accepting edge.
  - Throughput is 1 per cycle with out_ready held high.
- Arithmetic:
  - Radix-2 shift-add; each stage adds WIDTH/STAGES partial products into a 2*WIDTH partial sum, carried with remaining operand bits.
  - Unsigned: result = a*b, exact in 2*WIDTH bits.
  - Signed: exact two's-complement product in 2*WIDTH bits (Baugh-Wooley or sign-extended partial products; implementer's choice).
  - Most-negative × most-negative gives +2^(2*WIDTH-2), which fits.
  - mode_signed travels with its transaction; mixed modes in flight are legal.
- Stall:
  - out_valid=1 && out_ready=0: result, out_tag and out_valid held stable.
  - No transaction is lost or duplicated; in_ready=0 for the same cycles.
- Drain/bubble:
  - on adv, an empty last stage drives out_valid=0; result/out_tag hold their previous values.
- Simultaneous output and input transfer in the same cycle is legal and is the full-throughput case.
- Reset mid-operation: outputs drop to 0 asynchronously. No stale result appears after release; the first out_valid comes STAGES edges after the first post-reset acceptance.
- Ordering: results emerge strictly in acceptance order; out_tag equals the in_tag of that transaction.

Test Plan:
1. Default params; rst 1→0, out_ready=1; a=b=1..9 on consecutive cycles, tags 1..9, unsigned → results 0x01,0x04,0x09,0x10,0x19,0x24,0x31,0x40,0x51 on consecutive cycles, first one right after the 4th edge counting the accepting edge; tags match.
2. Mode mix: (8,8,s) → 0x40; (15,7,s) → 0xF9 (-7); (15,7,u) → 0x69; (8,7,s) → 0xC8 (-56), back-to-back, in order.
3. Backpressure: fill pipe, drop out_ready for 3 cycles → in_ready=0 for those 3 cycles; result/out_tag held; on release, every tag appears exactly once, in order.
4. Bubbles: in_valid toggling 1,0,1,0 with a=3,b=5 → out_valid toggles 1,0,1,0 with result 0x0F, after the same latency.
5. Async reset asserted mid-clock with 3 transactions in flight → out_valid=0 and result=0 before the next edge; after release, no out_valid until a new acceptance plus 4 edges.
6. WIDTH=8, STAGES=2: 255×255 unsigned → 0xFE01; -128×-128 signed → 0x4000; -1×127 signed → 0xFF81; latency 2 edges. Repeat at STAGES=1 → latency 1.

Source files
------------

// File: rtl/pipe_mult.sv
// ---------------------------------------------------------------------------
// pipe_mult
//
// Parametrised pipelined integer multiplier with a valid/ready handshake.
// Each pipeline stage adds WIDTH/STAGES radix-2 partial products into a
// 2*WIDTH running sum. The operands travel with the sum: the multiplicand
// shifts left and the multiplier shifts right. Each transaction carries its
// own signed/unsigned mode and a sideband tag. The tag passes through
// unchanged and stays aligned with its product.
//
// Parameters:
//   WIDTH   operand width in bits (>= 2)
//   STAGES  number of pipeline register stages (1..WIDTH, divides WIDTH)
//   TAG_W   width of the sideband tag
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operands/mode/tag valid this cycle
//   in_ready     block accepts input this cycle (equals pipeline advance)
//   data_a       multiplicand
//   data_b       multiplier
//   mode_signed  1 = two's-complement operands, 0 = unsigned
//   in_tag       sideband tag of the incoming transaction
//   out_valid    result/out_tag valid
//   out_ready    consumer accepts the result this cycle
//   result       exact 2*WIDTH-bit product
//   out_tag      tag of the transaction shown on result
// ---------------------------------------------------------------------------
module pipe_mult #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  input  logic                 mode_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [TAG_W-1:0]     out_tag
);

  // Multiplier bits consumed per stage, and the width of the product.
  localparam int K = WIDTH / STAGES;
  localparam int P = 2 * WIDTH;

  // Illegal parameter combinations stop elaboration.
  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_mult: illegal WIDTH/STAGES combination");
  end

  // Per-stage pipeline registers. Index 0 is the first stage. The last
  // stage holds the visible result. The operand copies kept in the last
  // stage are never read.
  logic             valid_q [STAGES];
  logic [P-1:0]     psum_q  [STAGES];
  logic [P-1:0]     a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             mode_q  [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];

  // Inputs seen by each stage, and the partial sum that stage produces.
  logic             src_valid [STAGES];
  logic [P-1:0]     src_psum  [STAGES];
  logic [P-1:0]     src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic             src_mode  [STAGES];
  logic [TAG_W-1:0] src_tag   [STAGES];
  logic [P-1:0]     sum_nxt   [STAGES];

  logic adv;

  // The whole pipe moves together. It moves whenever the output register
  // is empty or is being drained this cycle. Otherwise everything freezes,
  // including stage 1, so accepting input is exactly the same condition.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign out_valid = valid_q[STAGES-1];
  assign result    = psum_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  // Route operands into each stage and form that stage's partial products.
  // In signed mode the multiplicand is sign-extended to 2*WIDTH bits. The
  // multiplier's MSB has weight -2^(WIDTH-1), so its partial product is
  // subtracted rather than added. Everything wraps modulo 2^(2*WIDTH), which
  // keeps the product exact.
  always_comb begin
    src_valid[0] = in_valid;
    src_psum[0]  = '0;
    src_a[0]     = mode_signed ? {{WIDTH{data_a[WIDTH-1]}}, data_a}
                               : {{WIDTH{1'b0}}, data_a};
    src_b[0]     = data_b;
    src_mode[0]  = mode_signed;
    src_tag[0]   = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = valid_q[s-1];
      src_psum[s]  = psum_q[s-1];
      src_a[s]     = a_q[s-1];
      src_b[s]     = b_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_tag[s]   = tag_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      sum_nxt[s] = src_psum[s];
      for (int j = 0; j < K; j++) begin
        if (src_b[s][j]) begin
          if (src_mode[s] && (s * K + j == WIDTH - 1)) begin
            sum_nxt[s] = sum_nxt[s] - (src_a[s] << j);
          end else begin
            sum_nxt[s] = sum_nxt[s] + (src_a[s] << j);
          end
        end
      end
    end
  end

  // Pipeline registers. Valid bits advance on every advance edge, so a
  // bubble propagates as valid=0. Data registers load only when a real
  // transaction arrives. As a result an empty last stage leaves the previous
  // result and tag on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        psum_q[s]  <= '0;
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        mode_q[s]  <= 1'b0;
        tag_q[s]   <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= src_valid[s];
        if (src_valid[s]) begin
          psum_q[s] <= sum_nxt[s];
          a_q[s]    <= src_a[s] << K;
          b_q[s]    <= src_b[s] >> K;
          mode_q[s] <= src_mode[s];
          tag_q[s]  <= src_tag[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_mult.sv
// ---------------------------------------------------------------------------
// tb_pipe_mult
//
// Scoreboard bench for pipe_mult. It drives three instances:
//   dut   : default parameters (4x4, 4 stages), with handshaking and stalls
//   dut82 : WIDTH=8, STAGES=2
//   dut81 : WIDTH=8, STAGES=1
// When a transaction is accepted, the drivers push the hand-computed product,
// the tag and the edge on which it must appear. Separate monitors compare
// every presented output against the head of the matching queue.
// ---------------------------------------------------------------------------
module tb_pipe_mult;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    int          due;
    int          snap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default-parameter instance signals
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] data_a = '0;
  logic [3:0] data_b = '0;
  logic       mode_signed = 1'b0;
  logic [3:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] out_tag;

  // Shared stimulus for the two 8-bit instances
  logic       w_in_valid = 1'b0;
  logic [7:0] w_a = '0;
  logic [7:0] w_b = '0;
  logic       w_mode = 1'b0;
  logic [3:0] w_tag = '0;
  logic       w_out_ready = 1'b1;

  logic        w2_in_ready, w2_out_valid;
  logic [15:0] w2_result;
  logic [3:0]  w2_out_tag;
  logic        w1_in_ready, w1_out_valid;
  logic [15:0] w1_result;
  logic [3:0]  w1_out_tag;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;
  int stall_cnt    = 0;

  exp_t q4[$];
  exp_t q82[$];
  exp_t q81[$];

  pipe_mult dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b),
    .mode_signed(mode_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  pipe_mult #(.WIDTH(8), .STAGES(2), .TAG_W(4)) dut82 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w2_in_ready),
    .data_a(w_a), .data_b(w_b),
    .mode_signed(w_mode), .in_tag(w_tag),
    .out_valid(w2_out_valid), .out_ready(w_out_ready),
    .result(w2_result), .out_tag(w2_out_tag)
  );

  pipe_mult #(.WIDTH(8), .STAGES(1), .TAG_W(4)) dut81 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w1_in_ready),
    .data_a(w_a), .data_b(w_b),
    .mode_signed(w_mode), .in_tag(w_tag),
    .out_valid(w1_out_valid), .out_ready(w_out_ready),
    .result(w1_result), .out_tag(w1_out_tag)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Global watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point. Every check is counted here.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  // Drive one slot on the default instance. The task is called right after a
  // falling edge. A valid transaction is held until in_ready allows it in,
  // and its expected output is queued at that point.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic m,
                               input logic [3:0] tag, input logic v, input logic [7:0] exp_res);
    exp_t e;
    int   guard;
    in_valid    = v;
    data_a      = a;
    data_b      = b;
    mode_signed = m;
    in_tag      = tag;
    #1;
    guard = 0;
    while (v && !in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (v && !in_ready) begin
      checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else if (v) begin
      e.res  = {8'h00, exp_res};
      e.tag  = tag;
      e.due  = edge_cnt + 4;
      e.snap = stall_cnt;
      q4.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drive one transaction into both 8-bit instances. Their consumer is
  // always ready, so acceptance must happen on the next edge.
  task automatic applyStimulusWide(input logic [7:0] a, input logic [7:0] b, input logic m,
                                   input logic [3:0] tag, input logic [15:0] exp_res);
    exp_t e;
    w_in_valid = 1'b1;
    w_a        = a;
    w_b        = b;
    w_mode     = m;
    w_tag      = tag;
    #1;
    checkOutput("w82_in_ready", {31'b0, w2_in_ready}, 32'd1);
    checkOutput("w81_in_ready", {31'b0, w1_in_ready}, 32'd1);
    e.res  = exp_res;
    e.tag  = tag;
    e.snap = 0;
    e.due  = edge_cnt + 2;
    q82.push_back(e);
    e.due  = edge_cnt + 1;
    q81.push_back(e);
    @(negedge clk);
    w_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the default instance. Every cycle with out_valid is compared
  // with the queue head, which also covers values held during a stall. The
  // entry is retired on an output transfer. Stalled edges push the
  // presentation edge later by one each.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (q4.size() == 0) begin
        checkOutput("q4_unexpected_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("q4_result", {24'b0, result}, {16'b0, q4[0].res});
        checkOutput("q4_tag", {28'b0, out_tag}, {28'b0, q4[0].tag});
        if (out_ready) begin
          checkOutput("q4_latency", edge_cnt, q4[0].due + stall_cnt - q4[0].snap);
          q4.delete(0);
        end
      end
      if (!out_ready) stall_cnt++;
    end
  end

  // Monitor for the WIDTH=8, STAGES=2 instance
  always @(negedge clk) begin
    #2;
    if (!rst && w2_out_valid) begin
      if (q82.size() == 0) begin
        checkOutput("q82_unexpected_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("q82_result", {16'b0, w2_result}, {16'b0, q82[0].res});
        checkOutput("q82_tag", {28'b0, w2_out_tag}, {28'b0, q82[0].tag});
        checkOutput("q82_latency", edge_cnt, q82[0].due);
        q82.delete(0);
      end
    end
  end

  // Monitor for the WIDTH=8, STAGES=1 instance
  always @(negedge clk) begin
    #2;
    if (!rst && w1_out_valid) begin
      if (q81.size() == 0) begin
        checkOutput("q81_unexpected_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("q81_result", {16'b0, w1_result}, {16'b0, q81[0].res});
        checkOutput("q81_tag", {28'b0, w1_out_tag}, {28'b0, q81[0].tag});
        checkOutput("q81_latency", edge_cnt, q81[0].due);
        q81.delete(0);
      end
    end
  end

  // Directed test sequence
  initial begin
    int guard;
    logic [7:0] sq [9];
    sq = '{8'h01, 8'h04, 8'h09, 8'h10, 8'h19, 8'h24, 8'h31, 8'h40, 8'h51};

    // Outputs must be cleared while reset is held
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_result", {24'b0, result}, 32'd0);
    checkOutput("reset_out_tag", {28'b0, out_tag}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Squares 1..9, back-to-back, unsigned
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(i[3:0], i[3:0], 1'b0, i[3:0], 1'b1, sq[i-1]);
    end
    idle(6);

    // Mixed signed/unsigned transactions in flight together
    applyStimulus(4'd8,  4'd8, 1'b1, 4'h1, 1'b1, 8'h40);
    applyStimulus(4'd15, 4'd7, 1'b1, 4'h2, 1'b1, 8'hF9);
    applyStimulus(4'd15, 4'd7, 1'b0, 4'h3, 1'b1, 8'h69);
    applyStimulus(4'd8,  4'd7, 1'b1, 4'h4, 1'b1, 8'hC8);
    idle(6);

    // Backpressure: fill the pipe, then stall the consumer for 3 cycles
    applyStimulus(4'd2, 4'd3, 1'b0, 4'hA, 1'b1, 8'h06);
    applyStimulus(4'd3, 4'd3, 1'b0, 4'hB, 1'b1, 8'h09);
    applyStimulus(4'd4, 4'd3, 1'b0, 4'hC, 1'b1, 8'h0C);
    applyStimulus(4'd5, 4'd3, 1'b0, 4'hD, 1'b1, 8'h0F);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid    = 1'b1;
      data_a      = 4'd6;
      data_b      = 4'd3;
      mode_signed = 1'b0;
      in_tag      = 4'hE;
      #1;
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    applyStimulus(4'd6, 4'd3, 1'b0, 4'hE, 1'b1, 8'h12);
    applyStimulus(4'd7, 4'd3, 1'b0, 4'hF, 1'b1, 8'h15);
    idle(8);

    // Bubbles alternate with real transactions
    applyStimulus(4'd3, 4'd5, 1'b0, 4'h5, 1'b1, 8'h0F);
    applyStimulus(4'd3, 4'd5, 1'b0, 4'h0, 1'b0, 8'h00);
    applyStimulus(4'd3, 4'd5, 1'b0, 4'h6, 1'b1, 8'h0F);
    applyStimulus(4'd3, 4'd5, 1'b0, 4'h0, 1'b0, 8'h00);
    idle(8);

    // Reset between edges while the pipe is full, with one result showing
    applyStimulus(4'd1, 4'd2, 1'b0, 4'h1, 1'b1, 8'h02);
    applyStimulus(4'd2, 4'd2, 1'b0, 4'h2, 1'b1, 8'h04);
    applyStimulus(4'd3, 4'd2, 1'b0, 4'h3, 1'b1, 8'h06);
    applyStimulus(4'd4, 4'd2, 1'b0, 4'h4, 1'b1, 8'h08);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_result", {24'b0, result}, 32'd0);
    checkOutput("midrst_out_tag", {28'b0, out_tag}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("post_reset_idle", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(4'd7, 4'd7, 1'b0, 4'h9, 1'b1, 8'h31);
    idle(6);

    // Wide instances: the same vectors go into both depths
    applyStimulusWide(8'd255, 8'd255, 1'b0, 4'h1, 16'hFE01);
    applyStimulusWide(8'h80,  8'h80,  1'b1, 4'h2, 16'h4000);
    applyStimulusWide(8'hFF,  8'h7F,  1'b1, 4'h3, 16'hFF81);
    applyStimulusWide(8'h80,  8'h7F,  1'b1, 4'h4, 16'hC080);
    applyStimulusWide(8'd200, 8'd3,   1'b0, 4'h5, 16'h0258);
    idle(2);

    // Every queued result must have come out
    guard = 0;
    while ((q4.size() != 0 || q82.size() != 0 || q81.size() != 0) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (q4.size() != 0 || q82.size() != 0 || q81.size() != 0) begin
      checkOutput("drain_pending", q4.size() + q82.size() + q81.size(), 32'd0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
